// File: rtl/gsensor_spi_responder_pkg.sv
// Shared types and constants for the accelerometer SPI responder.
// Register map follows the ADXL345 layout used by the filter block.
package gsensor_spi_responder_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] RST_BW_RATE      = 8'h0A;
  localparam logic [7:0] RST_POWER_CTL    = 8'h00;
  localparam logic [7:0] RST_DATA_FORMAT  = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  // Address after a data byte: multi-byte walks and wraps, single stays.
  function automatic logic [5:0] next_addr(
    input logic [5:0] a,
    input logic       mb
  );
    return mb ? a + 6'd1 : a;
  endfunction

endpackage

// File: rtl/gsensor_spi_responder_if.sv
// Four-wire SPI bundle between the filter's master and this responder.
// The master modport drives clock, select and data; the slave answers.
interface gsensor_spi_responder_if;

  logic sclk;
  logic cs_n;
  logic sdi;
  logic sdo;
  logic sdo_oe;

  modport master (
    output sclk,
    output cs_n,
    output sdi,
    input  sdo,
    input  sdo_oe
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  sdi,
    output sdo,
    output sdo_oe
  );

endinterface

// File: rtl/gsensor_spi_responder_sync_edge.sv
// Synchronizers for sclk/cs_n/sdi plus edge detect on sclk and cs_n.
// Edges are suppressed until the chain holds real samples after reset.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic sdi,
  output logic sdi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall
);

  localparam int M = SYNC_STAGES - 1;

  logic [M:0]           sclk_q;
  logic [M:0]           cs_q;
  logic [M:0]           sdi_q;
  logic                 sclk_d;
  logic                 cs_d;
  logic [SYNC_STAGES:0] prime;
  logic                 armed;

  // Shift each line through the chain; prime fills with ones after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= '1;
      cs_q   <= '1;
      sdi_q  <= '0;
      sclk_d <= 1'b1;
      cs_d   <= 1'b1;
      prime  <= '0;
    end else begin
      sclk_q <= {sclk_q[M-1:0], sclk};
      cs_q   <= {cs_q[M-1:0], cs_n};
      sdi_q  <= {sdi_q[M-1:0], sdi};
      sclk_d <= sclk_q[M];
      cs_d   <= cs_q[M];
      prime  <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign armed     = prime[SYNC_STAGES];
  assign sdi_s     = sdi_q[M];
  assign sclk_rise = armed &  sclk_q[M] & ~sclk_d;
  assign sclk_fall = armed & ~sclk_q[M] &  sclk_d;
  assign cs_rise   = armed &  cs_q[M]   & ~cs_d;
  assign cs_fall   = armed & ~cs_q[M]   &  cs_d;

endmodule

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 slave modelling the accelerometer register interface.
// Oversamples the SPI lines in the clk domain; samples come from ports.
module gsensor_spi_responder
  import gsensor_spi_responder_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  gsensor_spi_responder_if.slave spi,
  input  logic signed [15:0]  sample_x,
  input  logic signed [15:0]  sample_y,
  input  logic signed [15:0]  sample_z,
  output logic [7:0]          reg_bw_rate,
  output logic [7:0]          reg_power_ctl,
  output logic [7:0]          reg_data_format,
  output logic                wr_strobe,
  output logic [5:0]          wr_addr
);

  logic        sdi_s;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        cs_rise;
  logic        cs_fall;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  shift_out;
  logic        rw;
  logic        mb;
  logic [5:0]  addr;
  logic [47:0] snap;
  logic        sdo_q;
  logic        oe_q;
  logic [7:0]  rx_byte;
  logic [7:0]  rd_byte;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk      (spi.sclk),
    .cs_n      (spi.cs_n),
    .sdi       (spi.sdi),
    .sdi_s     (sdi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall)
  );

  assign rx_byte    = {shift_in, sdi_s};
  assign spi.sdo    = sdo_q;
  assign spi.sdo_oe = oe_q;

  // Read mux over the register map; samples come from the frame snapshot.
  always_comb begin
    rd_byte = 8'h00;
    unique case (1'b1)
      addr == ADDR_DEVID:       rd_byte = DEVID;
      addr == ADDR_BW_RATE:     rd_byte = reg_bw_rate;
      addr == ADDR_POWER_CTL:   rd_byte = reg_power_ctl;
      addr == ADDR_DATA_FORMAT: rd_byte = reg_data_format;
      addr == ADDR_DATAX0:      rd_byte = snap[7:0];
      addr == ADDR_DATAX1:      rd_byte = snap[15:8];
      addr == ADDR_DATAY0:      rd_byte = snap[23:16];
      addr == ADDR_DATAY1:      rd_byte = snap[31:24];
      addr == ADDR_DATAZ0:      rd_byte = snap[39:32];
      addr == ADDR_DATAZ1:      rd_byte = snap[47:40];
      default:                  rd_byte = 8'h00;
    endcase
  end

  // Frame FSM: command capture, read shift-out, write commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shift_in        <= '0;
      shift_out       <= '0;
      rw              <= 1'b0;
      mb              <= 1'b0;
      addr            <= '0;
      snap            <= '0;
      sdo_q           <= 1'b0;
      oe_q            <= 1'b0;
      wr_strobe       <= 1'b0;
      wr_addr         <= '0;
      reg_bw_rate     <= RST_BW_RATE;
      reg_power_ctl   <= RST_POWER_CTL;
      reg_data_format <= RST_DATA_FORMAT;
    end else begin
      wr_strobe <= 1'b0;
      if (cs_rise) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sdo_q   <= 1'b0;
        oe_q    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
              snap    <= {sample_z, sample_y, sample_x};
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shift_in <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw    <= rx_byte[7];
                mb    <= rx_byte[6];
                addr  <= rx_byte[5:0];
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (sclk_fall && rw) begin
              if (bit_cnt == 3'd0) begin
                sdo_q     <= rd_byte[7];
                shift_out <= {rd_byte[6:0], 1'b0};
                oe_q      <= 1'b1;
              end else begin
                sdo_q     <= shift_out[7];
                shift_out <= {shift_out[6:0], 1'b0};
              end
            end
            if (sclk_rise) begin
              shift_in <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= next_addr(addr, mb);
                if (!rw) begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                  unique case (1'b1)
                    addr == ADDR_BW_RATE:
                      reg_bw_rate <= rx_byte;
                    addr == ADDR_POWER_CTL:
                      reg_power_ctl <= rx_byte;
                    addr == ADDR_DATA_FORMAT:
                      reg_data_format <= rx_byte;
                    default: ;
                  endcase
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Directed bench for the accelerometer SPI responder.
// Acts as a mode-3 SPI master with hand-computed expected bytes.
module tb_gsensor_spi_responder;

  localparam int HP = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] sample_x;
  logic signed [15:0] sample_y;
  logic signed [15:0] sample_z;
  logic [7:0]         reg_bw_rate;
  logic [7:0]         reg_power_ctl;
  logic [7:0]         reg_data_format;
  logic               wr_strobe;
  logic [5:0]         wr_addr;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_strb = 0;
  int         s0;
  int         flip_after = -1;
  logic [5:0] last_wa = '0;
  logic [7:0] txb [8];
  logic [7:0] rxb [8];
  logic [7:0] mbx [6];
  logic       oe_cmd;
  logic       oe_dat;
  logic [7:0] r;
  logic       a;
  logic       b;

  gsensor_spi_responder_if bus();

  gsensor_spi_responder #(
    .DEVID       (8'hE5),
    .SYNC_STAGES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .spi             (bus),
    .sample_x        (sample_x),
    .sample_y        (sample_y),
    .sample_z        (sample_z),
    .reg_bw_rate     (reg_bw_rate),
    .reg_power_ctl   (reg_power_ctl),
    .reg_data_format (reg_data_format),
    .wr_strobe       (wr_strobe),
    .wr_addr         (wr_addr)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      n_strb  = n_strb + 1;
      last_wa = wr_addr;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input  logic [7:0] tx,
                      input  int         nbits,
                      output logic [7:0] rx,
                      output logic       oe_any,
                      output logic       oe_all);
    rx     = '0;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.sclk = 1'b0;
      bus.sdi  = tx[i];
      repeat (HP) @(negedge clk);
      rx[i]  = bus.sdo;
      oe_any = oe_any | bus.sdo_oe;
      oe_all = oe_all & bus.sdo_oe;
      bus.sclk = 1'b1;
      repeat (HP) @(negedge clk);
    end
  endtask

  task automatic cs_lo();
    bus.cs_n = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic cs_hi();
    repeat (HP) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (2 * HP) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] cmd, input int n);
    logic [7:0] rr;
    logic       aa;
    logic       bb;
    cs_lo();
    xfer(cmd, 8, rr, aa, bb);
    oe_cmd = aa;
    oe_dat = 1'b1;
    for (int k = 0; k < n; k++) begin
      xfer(txb[k], 8, rr, aa, bb);
      rxb[k] = rr;
      oe_dat = oe_dat & bb;
      if (k == flip_after) sample_x = 16'hAAAA;
    end
    cs_hi();
  endtask

  initial begin
    reset    = 1'b1;
    bus.sclk = 1'b1;
    bus.cs_n = 1'b1;
    bus.sdi  = 1'b0;
    sample_x = '0;
    sample_y = '0;
    sample_z = '0;
    for (int i = 0; i < 8; i++) txb[i] = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_sdo", bus.sdo, 0);
    chk("rst_oe", bus.sdo_oe, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_wa", wr_addr, 0);
    chk("rst_bw", reg_bw_rate, 8'h0A);
    chk("rst_pwr", reg_power_ctl, 8'h00);
    chk("rst_fmt", reg_data_format, 8'h00);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // single read of DEVID
    frame(8'h80, 1);
    chk("devid", rxb[0], 8'hE5);
    chk("devid_oe_cmd", oe_cmd, 0);
    chk("devid_oe_dat", oe_dat, 1);
    chk("idle_oe", bus.sdo_oe, 0);
    chk("idle_sdo", bus.sdo, 0);

    // multi-byte sample read
    sample_x = 16'h0123;
    sample_y = 16'hFF80;
    sample_z = 16'h7FFE;
    mbx[0] = 8'h23; mbx[1] = 8'h01;
    mbx[2] = 8'h80; mbx[3] = 8'hFF;
    mbx[4] = 8'hFE; mbx[5] = 8'h7F;
    frame(8'hF2, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("mb_rd%0d", i), rxb[i], mbx[i]);

    // snapshot coherence: X changes after first byte
    flip_after = 0;
    frame(8'hF2, 6);
    flip_after = -1;
    for (int i = 0; i < 6; i++) chk($sformatf("coh%0d", i), rxb[i], mbx[i]);

    // single write to POWER_CTL
    s0 = n_strb;
    txb[0] = 8'h08;
    frame(8'h2D, 1);
    chk("wr_pwr", reg_power_ctl, 8'h08);
    chk("wr_nstrb", n_strb - s0, 1);
    chk("wr_wa", last_wa, 6'h2D);
    chk("wr_oe", oe_dat, 0);

    // multi-byte write at BW_RATE
    s0 = n_strb;
    txb[0] = 8'h0B;
    txb[1] = 8'h08;
    frame(8'h6C, 2);
    chk("mbwr_bw", reg_bw_rate, 8'h0B);
    chk("mbwr_pwr", reg_power_ctl, 8'h08);
    chk("mbwr_nstrb", n_strb - s0, 2);
    chk("mbwr_wa", last_wa, 6'h2D);

    // read back
    frame(8'hEC, 2);
    chk("rb_bw", rxb[0], 8'h0B);
    chk("rb_pwr", rxb[1], 8'h08);

    // write to read-only DEVID strobes but changes nothing
    s0 = n_strb;
    txb[0] = 8'h55;
    frame(8'h00, 1);
    chk("ro_nstrb", n_strb - s0, 1);
    chk("ro_wa", last_wa, 6'h00);
    txb[0] = 8'h00;
    frame(8'h80, 1);
    chk("ro_devid", rxb[0], 8'hE5);

    // abort mid-write
    s0 = n_strb;
    cs_lo();
    xfer(8'h31, 8, r, a, b);
    xfer(8'hFF, 5, r, a, b);
    cs_hi();
    chk("ab_fmt", reg_data_format, 8'h00);
    chk("ab_nstrb", n_strb - s0, 0);
    chk("ab_oe", bus.sdo_oe, 0);
    frame(8'hB1, 1);
    chk("ab_rd_fmt", rxb[0], 8'h00);

    // address wrap 0x3F -> 0x00
    frame(8'hFF, 2);
    chk("wrap0", rxb[0], 8'h00);
    chk("wrap1", rxb[1], 8'hE5);

    // reset during second byte
    cs_lo();
    xfer(8'hFF, 8, r, a, b);
    xfer(8'h00, 8, r, a, b);
    xfer(8'h00, 4, r, a, b);
    chk("pre_rst_oe", bus.sdo_oe, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_oe", bus.sdo_oe, 0);
    chk("mid_rst_sdo", bus.sdo, 0);
    chk("mid_rst_bw", reg_bw_rate, 8'h0A);
    chk("mid_rst_pwr", reg_power_ctl, 8'h00);
    chk("mid_rst_wa", wr_addr, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    s0 = n_strb;
    xfer(8'h80, 8, r, a, b);
    xfer(8'h00, 8, r, a, b);
    chk("post_rst_oe", a, 0);
    cs_hi();
    chk("post_rst_nstrb", n_strb - s0, 0);
    frame(8'h80, 1);
    chk("post_rst_devid", rxb[0], 8'hE5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gsensor_spi_responder.md
Name: gsensor_spi_responder

Overview:
- Synthesizable SPI slave that models the board accelerometer's register interface: 4-wire SPI, mode 3, ADXL345-style command byte and register map.
- Sits on the far end of the filter block's SPI master. It lets the filter be exercised in simulation, and on a second board, with controlled X/Y/Z samples driven from input ports.
- Runs entirely in the system clock domain and oversamples SCLK, CS_N and SDI.

Parameters:
- DEVID, 8'hE5, value returned from register 0x00.
- SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/sdi; minimum 2.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from master; idles high.
- cs_n  in  1  SPI chip select, active low.
- sdi  in  1  master-to-slave data.
- sdo  out  1  slave-to-master data.
- sdo_oe  out  1  sdo output enable; high only while a read data byte is being shifted.
- sample_x  in  16  signed X sample, two's complement.
- sample_y  in  16  signed Y sample.
- sample_z  in  16  signed Z sample.
- reg_bw_rate  out  8  register 0x2C.
- reg_power_ctl  out  8  register 0x2D.
- reg_data_format  out  8  register 0x31.
- wr_strobe  out  1  one-clk pulse when any register write commits.
- wr_addr  out  6  address of the last committed write; valid when wr_strobe is high.

Behaviour:
- Reset values:
  - sdo=0, sdo_oe=0, wr_strobe=0, wr_addr=0.
  - reg_bw_rate=8'h0A, reg_power_ctl=8'h00, reg_data_format=8'h00.
  - FSM in IDLE; sync flops load the idle values (sclk=1, cs_n=1).
- Synchronization: sclk, cs_n and sdi each pass through SYNC_STAGES flops. Edge detection is done on the synchronized sclk and cs_n.
- Timing limit: SCLK half-period must be at least 4 clk cycles (SCLK ≤ 6.25 MHz). Faster SCLK is unsupported.
- Sampling and driving:
  - sdi is captured on a detected sclk rising edge.
  - sdo changes on a detected sclk falling edge, 1 clk after detection.
- FSM states:
  - IDLE: wait for cs_n falling.
  - CMD: shift in 8 bits, MSB first.
  - DATA: shift bytes until CS deasserts.
- IDLE->CMD on cs_n falling. Also on cs_n falling: snapshot sample_x/y/z into a 48-bit holding register, so a multi-byte read is coherent.
- Command byte layout: bit7 = R/W (1 = read), bit6 = MB (multi-byte), bits5:0 = start address.
- CMD->DATA on the 8th rising edge; the bit counter resets to 0.
- Read byte:
  - The read byte is loaded on the first sclk falling edge after the byte boundary. That same edge drives bit7 and sets sdo_oe=1.
  - Each later falling edge shifts out the next bit.
- Write byte: commits on its 8th rising edge. wr_strobe pulses 1 clk after that edge. Writes to read-only or unmapped addresses still strobe but change nothing.
- Address step after each data byte:
  - MB=1: address increments, wrapping 0x3F->0x00.
  - MB=0: address stays fixed, so repeated bytes access the same register.
- Register map (read):
  - 0x00 = DEVID.
  - 0x2C, 0x2D, 0x31 = writable registers.
  - 0x32/0x33 = snapshot X low/high byte; 0x34/0x35 = Y low/high; 0x36/0x37 = Z low/high.
  - All other addresses read 8'h00.
- Writable registers: 0x2C, 0x2D, 0x31 only.
- cs_n rising, from any state: return to IDLE within 1 clk of detection. sdo_oe=0 and sdo=0. A partially received write byte or command is discarded with no strobe.
- cs_n falling while not in IDLE is not possible by construction; the FSM always returns through IDLE.
- reset asserted mid-transfer: all outputs return to their reset values immediately. After reset deasserts, the current frame is ignored until a fresh cs_n falling edge.
- sclk edges while cs_n is high: ignored.

Decomposition:
- Shared package:
  - Register address constants: ADDR_DEVID, ADDR_BW_RATE, ADDR_POWER_CTL, ADDR_DATA_FORMAT, ADDR_DATAX0..ADDR_DATAZ1.
  - Reset-value constants.
  - FSM state enum {IDLE, CMD, DATA}.
- One sub-module: spi_sync_edge. It holds the synchronizer chain plus rise/fall detect for sclk and cs_n, and is instantiated once for the three lines.

Test Plan:
- Single read of 0x00: command 8'h80, one data byte -> master receives 8'hE5; sdo_oe high only during the data byte.
- Multi-byte read: sample_x=16'h0123, sample_y=16'hFF80, sample_z=16'h7FFE; command 8'hF2 (read, MB, 0x32), 6 bytes -> received 23 01 80 FF FE 7F.
- Snapshot coherence: same as the multi-byte read, but sample_x changes to 16'hAAAA after byte 1 -> all 6 bytes still match the values present at cs_n fall.
- Write then read back:
  - Command 8'h2D, data 8'h08 -> reg_power_ctl=8'h08 and one wr_strobe with wr_addr=6'h2D.
  - Command 8'h6C (MB write at 0x2C), data 0B 08 -> reg_bw_rate=8'h0B, reg_power_ctl=8'h08; two strobes.
- Abort mid-write: command 8'h31, then 5 data bits, then cs_n high -> reg_data_format stays 8'h00, no wr_strobe, FSM in IDLE, sdo_oe=0.
- Wrap and reset:
  - MB read starting at 0x3F for 2 bytes -> returns 00 then E5.
  - Assert reset during the second byte -> all outputs return to reset values; the next frame reading 0x00 returns E5.
